muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit with architectural HI/LO registers. It replaces the datapath's combinational `multu` and `spreg` pair. The unit executes MULTU, MULT, DIVU and DIV one bit per cycle and drives `busy` so the controller can stall the PC. It also supports direct HI/LO writes (MTHI/MTLO) and a `cancel` input, which lets the interrupt path abort an in-flight operation.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings, state type and sign helper for muldiv_unit
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Widest value the sign helper handles; covers 2*WIDTH products up to WIDTH=127.
    localparam int NEG_MAX_W = 256;

    // Two's-complement negate when en is set, pass-through otherwise.
    // Callers zero-extend into NEG_MAX_W bits and keep only the low slice they need,
    // so the same helper serves both the absolute value and the result fix-up.
    function automatic logic [NEG_MAX_W-1:0] neg_if(input logic [NEG_MAX_W-1:0] x,
                                                   input logic en);
        return en ? (~x + NEG_MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
import muldiv_pkg::*;

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             sa_q, sb_q;
    logic             dz_q;
    logic [WIDTH-1:0] opnd_q;
    logic [AW-1:0]    acc_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, div0_q;

    logic load, step, fix_wr, mt_en;

    // ---------------------------------------------------------------- operand prep
    logic                 is_signed_op, is_div_op, sgn_a, sgn_b, dz;
    logic [NEG_MAX_W-1:0] a_abs_ext, b_abs_ext;
    logic [WIDTH-1:0]     a_abs, b_abs, init_low;

    assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign is_div_op    = op[1];
    assign sgn_a        = is_signed_op & a[WIDTH-1];
    assign sgn_b        = is_signed_op & b[WIDTH-1];
    assign dz           = is_div_op && (b == '0);
    assign a_abs_ext    = neg_if(NEG_MAX_W'(a), sgn_a);
    assign b_abs_ext    = neg_if(NEG_MAX_W'(b), sgn_b);
    assign a_abs        = a_abs_ext[WIDTH-1:0];
    assign b_abs        = b_abs_ext[WIDTH-1:0];
    // Divide-by-zero skips CALC, so the raw dividend is parked where FIX reads HI from.
    assign init_low     = is_div_op ? (dz ? a : a_abs) : b_abs;

    // ---------------------------------------------------------------- one iteration
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_next;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [AW-1:0]    div_next;

    // Shift-add: conditionally add the multiplicand to the upper half, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift {rem, quot} left, keep the trial difference if non-negative.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    assign div_ok   = ~div_diff[WIDTH+1];
    assign div_next = {(div_ok ? div_diff[WIDTH:0] : rem_sh), acc_q[WIDTH-2:0], div_ok};

    // ---------------------------------------------------------------- sign fix-up
    logic [NEG_MAX_W-1:0] prod_ext, quot_ext, rem_ext;

    assign prod_ext = neg_if(NEG_MAX_W'(acc_q[2*WIDTH-1:0]), sa_q ^ sb_q);
    assign quot_ext = neg_if(NEG_MAX_W'(acc_q[WIDTH-1:0]), sa_q ^ sb_q);
    assign rem_ext  = neg_if(NEG_MAX_W'(acc_q[2*WIDTH-1:WIDTH]), sa_q);

    logic unused_bits;
    assign unused_bits = ^{acc_q[2*WIDTH],
                           a_abs_ext[NEG_MAX_W-1:WIDTH], b_abs_ext[NEG_MAX_W-1:WIDTH],
                           prod_ext[NEG_MAX_W-1:2*WIDTH], quot_ext[NEG_MAX_W-1:WIDTH],
                           rem_ext[NEG_MAX_W-1:WIDTH]};

    // ---------------------------------------------------------------- control FSM
    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix_wr  = 1'b0;
        mt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = dz ? ST_FIX : ST_CALC;
                end else begin
                    mt_en = 1'b1;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel) fix_wr = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, iteration datapath, HI/LO writes and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            done_q <= fix_wr;
            if (load) begin
                cnt_q    <= '0;
                is_div_q <= is_div_op;
                sa_q     <= sgn_a;
                sb_q     <= sgn_b;
                dz_q     <= dz;
                div0_q   <= 1'b0;
                opnd_q   <= is_div_op ? b_abs : a_abs;
                acc_q    <= {{(WIDTH + 1){1'b0}}, init_low};
            end
            if (step) begin
                cnt_q <= cnt_q + CW'(1);
                acc_q <= is_div_q ? div_next : mul_next;
            end
            if (fix_wr) begin
                if (dz_q) begin
                    hi_q   <= acc_q[WIDTH-1:0];
                    lo_q   <= '1;
                    div0_q <= 1'b1;
                end else if (is_div_q) begin
                    hi_q <= rem_ext[WIDTH-1:0];
                    lo_q <= quot_ext[WIDTH-1:0];
                end else begin
                    hi_q <= prod_ext[2*WIDTH-1:WIDTH];
                    lo_q <= prod_ext[WIDTH-1:0];
                end
            end
            if (mt_en) begin
                if (hi_wr) hi_q <= wdata;
                if (lo_wr) lo_q <= wdata;
            end
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, cancel, hi_wr, lo_wr;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic [31:0] hi, lo;
    logic        busy, done, div0;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present start for exactly one rising edge; returns 1 ns after that edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edges counted until done is seen 1 ns after an edge; -1 if the bound expires.
    task automatic wait_done(input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cancel = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        #12;
        check("rst_hi",   64'(hi),   64'h0);
        check("rst_lo",   64'(lo),   64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_div0", 64'(div0), 64'h0);
        #10 reset = 1'b1;

        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_first", 64'(busy), 64'h1);
        wait_done(100, lat);
        check("multu_lat",  64'(lat),  64'(33));
        check("multu_hi",   64'(hi),   64'hFFFF_FFFE);
        check("multu_lo",   64'(lo),   64'h0000_0001);
        check("multu_idle", 64'(busy), 64'h0);

        start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done(100, lat);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFF1);

        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(100, lat);
        check("div_m7_2_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_m7_2_hi", 64'(hi), 64'hFFFF_FFFF);

        start_op(2'b11, 32'd7, 32'hFFFF_FFFE);
        wait_done(100, lat);
        check("div_7_m2_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_7_m2_hi", 64'(hi), 64'h0000_0001);

        start_op(2'b10, 32'd100, 32'd7);
        wait_done(100, lat);
        check("divu_lat", 64'(lat), 64'(33));
        check("divu_lo",  64'(lo),  64'd14);
        check("divu_hi",  64'(hi),  64'd2);

        start_op(2'b10, 32'h0000_1234, 32'd0);
        wait_done(100, lat);
        check("div0_lat",  64'(lat),  64'(1));
        check("div0_flag", 64'(div0), 64'h1);
        check("div0_hi",   64'(hi),   64'h0000_1234);
        check("div0_lo",   64'(lo),   64'hFFFF_FFFF);

        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div0_cleared", 64'(div0), 64'h0);
        wait_done(100, lat);
        check("divmin_lo", 64'(lo), 64'h8000_0000);
        check("divmin_hi", 64'(hi), 64'h0);

        @(negedge clk);
        hi_wr = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 hi_wr = 1'b0;
        check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
        check("mthi_lo", 64'(lo), 64'h8000_0000);

        start_op(2'b00, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        check("busy_hold_hi", 64'(hi), 64'hA5A5_A5A5);
        start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100; hi_wr = 1'b1; wdata = 32'h0;
        @(posedge clk);
        #1 start = 1'b0; hi_wr = 1'b0;
        check("busy_wr_ignored", 64'(hi), 64'hA5A5_A5A5);
        wait_done(100, lat);
        check("restart_ignored_lat", 64'(lat), 64'(28));
        check("mul67_hi", 64'(hi), 64'h0);
        check("mul67_lo", 64'(lo), 64'd42);

        start_op(2'b10, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        check("cancel_busy_before", 64'(busy), 64'h1);
        @(posedge clk);
        #1 cancel = 1'b0;
        check("cancel_busy_after", 64'(busy), 64'h0);
        wait_done(40, lat);
        check("cancel_no_done", 64'(lat), 64'(-1));
        check("cancel_hi", 64'(hi), 64'h0);
        check("cancel_lo", 64'(lo), 64'd42);

        @(negedge clk);
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1; lo_wr = 1'b1; wdata = 32'h0000_DEAD;
        @(posedge clk);
        #1 start = 1'b0; lo_wr = 1'b0;
        check("start_wins_lo", 64'(lo), 64'd42);
        wait_done(100, lat);
        check("mul23_lo", 64'(lo), 64'd6);

        start_op(2'b01, 32'd5, 32'd5);
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_hi",   64'(hi),   64'h0);
        check("arst_lo",   64'(lo),   64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_done", 64'(done), 64'h0);
        @(negedge clk);
        reset = 1'b1;

        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(100, lat);
        check("mult_m1_m1_hi", 64'(hi), 64'h0);
        check("mult_m1_m1_lo", 64'(lo), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
